pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the enable and bubble controls of the IF_ID, ID_EX, EX_ME and ME_WB pipeline registers.
- Resolves three hazard classes: load-use, taken branch/jump, and data-memory wait states. Wait states are tracked by a small FSM with timeout detection.
- Keeps saturating stall and flush performance counters.

Parameters:
- TIMEOUT, 16, maximum stalled cycles allowed for one data-memory access before an error is raised (>=2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_D  in  5  source register 1 of the instruction in Decode.
- rs2_D  in  5  source register 2 of the instruction in Decode.
- use_rs1_D  in  1  Decode instruction reads rs1.
- use_rs2_D  in  1  Decode instruction reads rs2.
- rd_E  in  5  destination register of the instruction in Execute.
- wb_ctrl_E  in  2  Execute writeback select: 00 ALU, 01 memory, 10 PC+4.
- we_reg_E  in  1  Execute instruction writes the register file.
- branch_taken_E  in  1  branch taken or jump redirect resolved in Execute.
- mem_req_M  in  1  Memory stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_F  out  1  hold the PC.
- stall_D  out  1  hold IF_ID.
- stall_E  out  1  hold ID_EX.
- stall_M  out  1  hold EX_ME.
- flush_D  out  1  clear IF_ID to a NOP.
- flush_E  out  1  clear ID_EX to a bubble.
- bubble_W  out  1  load a bubble into ME_WB (we_reg 0).
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles with stall_F=1.
- flush_cnt  out  CNT_W  cycles with flush_D=1.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. A wait counter wait_cnt is sized to hold TIMEOUT.
- While rst=1:
  - next state = RUN; wait_cnt, stall_cnt, flush_cnt and mem_err are cleared.
  - All stall, flush and bubble outputs are forced to 0 combinationally.
- Hazard outputs are combinational from the inputs and the current state; the latency from an input to its response is 0 cycles.
- mem_wait condition (RUN or MEM_WAIT): mem_req_M=1 and mem_ready=0.
  - Drives stall_F, stall_D, stall_E and stall_M to 1, and bubble_W to 1.
  - Forces flush_D=0 and flush_E=0; a pending branch in Execute is held and flushes after release.
- Load-use condition: wb_ctrl_E=01, we_reg_E=1, rd_E!=0, and (rd_E==rs1_D with use_rs1_D) or (rd_E==rs2_D with use_rs2_D).
  - Applies only when there is no mem_wait and no branch_taken_E.
  - Drives stall_F=1, stall_D=1 and flush_E=1 for exactly one cycle.
  - Re-evaluated each cycle; after the bubble, rd_E no longer matches.
- Branch condition: branch_taken_E=1 with no mem_wait.
  - Drives flush_D=1 and flush_E=1, with no stall.
  - Suppresses load-use, because the Decode instruction is squashed.
- Priority order: ERR, then mem_wait, then branch, then load-use, then none.
- FSM transitions:
  - RUN to MEM_WAIT on mem_wait; wait_cnt<=1.
  - MEM_WAIT with mem_ready=1: stalls drop in the same cycle; next state RUN; wait_cnt<=0.
  - MEM_WAIT with mem_ready=0 and wait_cnt==TIMEOUT-1: next state ERR. Otherwise wait_cnt++.
  - In MEM_WAIT, mem_req_M=0 is a protocol violation; the FSM returns to RUN.
  - ERR: all four stalls are held at 1, bubble_W=1, flushes are 0, and mem_err=1. The only exit is rst.
  - mem_err is registered: it equals 1 exactly when the state is ERR.
- Counters: registered, incremented on the cycle the condition holds, and saturating at all ones (no wrap).

Test Plan:
- Load-use: lw x5 in Execute (rd_E=5, wb_ctrl_E=01, we_reg_E=1); rs1_D=5 with use_rs1_D=1.
  - Expect stall_F=stall_D=flush_E=1 for 1 cycle, then all 0; stall_cnt=1.
  - Repeat with rd_E=0: expect no stall.
- Branch beats load-use: branch_taken_E=1 together with a load-use match.
  - Expect flush_D=flush_E=1 and stall_F=0; flush_cnt increments by 1.
- Memory wait: mem_req_M=1, with mem_ready=0 for 3 cycles then 1.
  - Expect stall_F/D/E/M=1 and bubble_W=1 for 3 cycles, 0 on the 4th; state back to RUN; stall_cnt=3.
- Branch during wait: branch_taken_E=1 throughout a 2-cycle wait.
  - Expect flush_D=flush_E=0 while stalled, and 1 on the release cycle.
- Timeout, TIMEOUT=8, mem_ready held at 0:
  - mem_err rises in cycle 9 after entry and stays 1 with stalls held.
  - rst pulse: next cycle mem_err=0, all outputs 0, counters 0.
- Counter saturation, CNT_W=4: 20 stalled cycles give stall_cnt=15, held there.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage RV32 pipeline with mem-wait FSM and perf counters
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic             use_rs1_D,
   input  logic             use_rs2_D,
   input  logic [4:0]       rd_E,
   input  logic [1:0]       wb_ctrl_E,
   input  logic             we_reg_E,
   input  logic             branch_taken_E,
   input  logic             mem_req_M,
   input  logic             mem_ready,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             bubble_W,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
   state_t state, state_nx;
   logic [WW-1:0] wait_cnt, wait_nx;
   logic in_err, mem_wait, branch, load_use, hold;
   // hazard resolution by priority (ERR, mem_wait, branch, load-use) and next-state logic
   always_comb begin
      in_err   = state == ERR;
      mem_wait = !in_err && mem_req_M && !mem_ready;
      branch   = !in_err && !mem_wait && branch_taken_E;
      load_use = !in_err && !mem_wait && !branch_taken_E && wb_ctrl_E == 2'b01 && we_reg_E && rd_E != 5'd0 &&
                 ((rd_E == rs1_D && use_rs1_D) || (rd_E == rs2_D && use_rs2_D));
      hold     = !rst && (in_err || mem_wait);
      stall_F  = hold || (!rst && load_use);
      stall_D  = stall_F;
      stall_E  = hold;
      stall_M  = hold;
      bubble_W = hold;
      flush_D  = !rst && branch;
      flush_E  = !rst && (branch || load_use);
      state_nx = state;
      wait_nx  = wait_cnt;
      case (state)
         RUN: begin
            state_nx = mem_wait ? MEM_WAIT : RUN;
            wait_nx  = mem_wait ? WW'(1) : '0;
         end
         MEM_WAIT: begin
            state_nx = (!mem_req_M || mem_ready) ? RUN : (wait_cnt == WW'(TIMEOUT - 1)) ? ERR : MEM_WAIT;
            wait_nx  = (!mem_req_M || mem_ready) ? '0 : (wait_cnt == WW'(TIMEOUT - 1)) ? wait_cnt : wait_cnt + 1'b1;
         end
         ERR: state_nx = ERR;
         default: begin
            state_nx = RUN;
            wait_nx  = '0;
         end
      endcase
   end
   // state, sticky error flag and saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         mem_err  <= state_nx == ERR;
         if (stall_F && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush_D && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checking of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
   localparam int TO = 8;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 0, rst = 1;
   logic [4:0] rs1_D, rs2_D, rd_E;
   logic use_rs1_D, use_rs2_D, we_reg_E, branch_taken_E, mem_req_M, mem_ready;
   logic [1:0] wb_ctrl_E;
   logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;
   int n_chk = 0, n_fail = 0;
   bit armed = 0;
   // model state: consecutive mem-wait cycles, sticky error, counters
   int m_run = 0, m_sc = 0, m_fc = 0;
   bit m_err = 0;

   pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rd_E(rd_E), .wb_ctrl_E(wb_ctrl_E), .we_reg_E(we_reg_E), .branch_taken_E(branch_taken_E),
      .mem_req_M(mem_req_M), .mem_ready(mem_ready), .stall_F(stall_F), .stall_D(stall_D),
      .stall_E(stall_E), .stall_M(stall_M), .flush_D(flush_D), .flush_E(flush_E), .bubble_W(bubble_W),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {rs1_D, rs2_D, rd_E, wb_ctrl_E} = '0;
      {use_rs1_D, use_rs2_D, we_reg_E, branch_taken_E, mem_req_M, mem_ready} = '0;
   endtask

   task automatic load_use(input logic [4:0] r);
      idle();
      rd_E = r; wb_ctrl_E = 2'b01; we_reg_E = 1; rs1_D = r; use_rs1_D = 1;
   endtask

   task automatic do_reset();
      rst = 1; idle(); tick(); rst = 0;
   endtask

   // compare process: expected outputs from the hazard rules, then advance the model by one clock
   always @(negedge clk) if (armed) begin
      bit mw, br, lu, sf, fd, fe, hd;
      logic [7+2*CW:0] got, exp;
      mw = !m_err && mem_req_M && !mem_ready;
      br = !m_err && !mw && branch_taken_E;
      lu = !m_err && !mw && !branch_taken_E && wb_ctrl_E == 2'b01 && we_reg_E && rd_E != 0 &&
           ((rd_E == rs1_D && use_rs1_D) || (rd_E == rs2_D && use_rs2_D));
      hd = !rst && (m_err || mw);
      sf = hd || (!rst && lu);
      fd = !rst && br;
      fe = !rst && (br || lu);
      exp = {sf, sf, hd, hd, fd, fe, hd, m_err, CW'(m_sc), CW'(m_fc)};
      got = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, mem_err, stall_cnt, flush_cnt};
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL outputs: got %b expected %b at %0t", got, exp, $time);
      end
      if (rst) begin
         m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
      end else begin
         if (sf && m_sc < CMAX) m_sc++;
         if (fd && m_fc < CMAX) m_fc++;
         m_run = mw ? m_run + 1 : 0;
         if (m_run == TO) m_err = 1;
      end
   end

   initial begin
      int thr, req_thr;
      idle();
      tick();
      armed = 1;
      do_reset();
      chk("reset_stall_cnt", stall_cnt, 0);
      chk("reset_mem_err", mem_err, 0);
      chk("reset_stall_F", stall_F, 0);
      // outputs are forced low while rst is asserted, even with a hazard present
      rst = 1; load_use(5); #1;
      chk("rst_masks_stall", stall_F, 0);
      chk("rst_masks_flush", flush_E, 0);
      tick(); rst = 0;
      // load-use: one-cycle stall, then the bubble clears it
      load_use(5); #1;
      chk("lu_stall_F", stall_F, 1);
      chk("lu_flush_E", flush_E, 1);
      chk("lu_stall_M", stall_M, 0);
      tick(); idle(); #1;
      chk("lu_release", stall_F, 0);
      tick();
      chk("lu_stall_cnt", stall_cnt, 1);
      load_use(0); #1;
      chk("lu_x0_no_stall", stall_F, 0);
      tick();
      // branch beats load-use
      load_use(7); branch_taken_E = 1; #1;
      chk("br_flush_D", flush_D, 1);
      chk("br_flush_E", flush_E, 1);
      chk("br_no_stall", stall_F, 0);
      tick(); idle();
      chk("br_flush_cnt", flush_cnt, 1);
      // memory wait of 3 cycles
      do_reset();
      mem_req_M = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mw_stall_M", stall_M, 1);
         chk("mw_bubble_W", bubble_W, 1);
         tick();
      end
      mem_ready = 1; #1;
      chk("mw_release", stall_F, 0);
      tick(); idle();
      chk("mw_stall_cnt", stall_cnt, 3);
      load_use(3); #1;
      chk("mw_back_to_run", stall_F & ~stall_M, 1);
      tick(); idle();
      // branch held during a 2-cycle wait, flushes on release
      do_reset();
      mem_req_M = 1; branch_taken_E = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("bw_no_flush", flush_D, 0);
         tick();
      end
      mem_ready = 1; #1;
      chk("bw_flush_on_release", flush_D, 1);
      tick(); idle();
      // timeout: mem_err rises in cycle 9 after entry
      do_reset();
      mem_req_M = 1;
      for (int k = 1; k <= TO; k++) begin
         tick();
         chk("to_mem_err", mem_err, k == TO ? 1 : 0);
      end
      idle(); #1;
      chk("err_stall_held", stall_M, 1);
      branch_taken_E = 1; #1;
      chk("err_no_flush", flush_D, 0);
      tick();
      chk("err_sticky", mem_err, 1);
      do_reset();
      chk("err_cleared", mem_err, 0);
      chk("err_cnt_cleared", stall_cnt, 0);
      chk("err_out_cleared", stall_F, 0);
      // counter saturation over 20 stalled cycles
      load_use(9);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall_cnt", stall_cnt, CMAX);
      tick(); tick();
      chk("sat_held", stall_cnt, CMAX);
      // randomized phase, biased blocks for short and long memory waits
      for (int b = 0; b < 30; b++) begin
         case ($urandom_range(0, 2))
            0: begin thr = 90; req_thr = 30; end
            1: begin thr = 50; req_thr = 50; end
            default: begin thr = 3; req_thr = 95; end
         endcase
         for (int i = 0; i < 100; i++) begin
            rst = $urandom_range(0, 63) == 0;
            rs1_D = 5'($urandom_range(0, 3));
            rs2_D = 5'($urandom_range(0, 3));
            rd_E = 5'($urandom_range(0, 3));
            use_rs1_D = 1'($urandom);
            use_rs2_D = 1'($urandom);
            wb_ctrl_E = 2'($urandom_range(0, 2));
            we_reg_E = 1'($urandom);
            branch_taken_E = $urandom_range(0, 5) == 0;
            mem_req_M = $urandom_range(0, 99) < req_thr;
            mem_ready = $urandom_range(0, 99) < thr;
            tick();
         end
      end
      rst = 0; idle();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
